// File: rtl/egress_router.sv
// Egress router: decodes the destination of each arbiter word and pushes it to one
// of four egress FIFOs, parking words in an in-order skid buffer when the target is full.
module egress_router #(
    parameter int DATA_W     = 10,
    parameter int SKID_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              almost_full_P4,
    input  logic              almost_full_P5,
    input  logic              almost_full_P6,
    input  logic              almost_full_P7,
    output logic              push_F4,
    output logic              push_F5,
    output logic              push_F6,
    output logic              push_F7,
    output logic [DATA_W-1:0] out_FIFO_4,
    output logic [DATA_W-1:0] out_FIFO_5,
    output logic [DATA_W-1:0] out_FIFO_6,
    output logic [DATA_W-1:0] out_FIFO_7,
    output logic              stall,
    output logic [CNT_W-1:0]  cnt_0,
    output logic [CNT_W-1:0]  cnt_1,
    output logic [CNT_W-1:0]  cnt_2,
    output logic [CNT_W-1:0]  cnt_3,
    output logic              overflow_err
);

    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CW = $clog2(SKID_DEPTH + 1);

    typedef enum logic {
        PASS,
        BUFFER
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              stall_q;
    logic              overflow_q, overflow_d;

    logic [DATA_W-1:0] skid_mem [SKID_DEPTH];

    logic [3:0]        af;
    logic [1:0]        in_dest;
    logic [DATA_W-1:0] head_word;
    logic [1:0]        head_dest;

    logic              issue_en;
    logic [DATA_W-1:0] issue_word;
    logic [1:0]        issue_dest;
    logic              append;
    logic              pop;
    logic [3:0]        dest_hit;

    logic              push_q [4];
    logic [DATA_W-1:0] out_q  [4];
    logic [CNT_W-1:0]  cnt_q  [4];

    assign af        = {almost_full_P7, almost_full_P6, almost_full_P5, almost_full_P4};
    assign in_dest   = data_in[DATA_W-1 -: 2];
    assign head_word = skid_mem[rd_ptr_q];
    assign head_dest = head_word[DATA_W-1 -: 2];

    // Issue selection: in PASS the incoming word may go straight out; in BUFFER only
    // the skid head may issue and every new word queues behind it.
    always_comb begin
        issue_en   = 1'b0;
        issue_word = data_in;
        append     = 1'b0;
        pop        = 1'b0;
        overflow_d = overflow_q;
        if (state_q == PASS) begin
            if (valid_in) begin
                if (!af[in_dest]) begin
                    issue_en = 1'b1;
                end else begin
                    append = 1'b1;
                end
            end
        end else begin
            if (!af[head_dest]) begin
                issue_en   = 1'b1;
                issue_word = head_word;
                pop        = 1'b1;
            end
            if (valid_in) begin
                // A full buffer still accepts the word when the head leaves this cycle.
                if (count_q == CW'(SKID_DEPTH) && !pop) begin
                    overflow_d = 1'b1;
                end else begin
                    append = 1'b1;
                end
            end
        end
    end

    assign issue_dest = issue_word[DATA_W-1 -: 2];

    always_comb begin
        wr_ptr_d = append ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (append && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !append) begin
            count_d = count_q - CW'(1);
        end
        state_d = (count_d != '0) ? BUFFER : PASS;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hit
            assign dest_hit[gi] = issue_en && (issue_dest == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PASS;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stall_q    <= (count_d != '0);
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (append && !reset) begin
            skid_mem[wr_ptr_q] <= data_in;
        end
    end

    // Per-destination output registers: data holds unless its own port is pushed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                push_q[i] <= 1'b0;
                out_q[i]  <= '0;
                cnt_q[i]  <= '0;
            end else begin
                push_q[i] <= dest_hit[i];
                if (dest_hit[i]) begin
                    out_q[i] <= issue_word;
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign push_F4      = push_q[0];
    assign push_F5      = push_q[1];
    assign push_F6      = push_q[2];
    assign push_F7      = push_q[3];
    assign out_FIFO_4   = out_q[0];
    assign out_FIFO_5   = out_q[1];
    assign out_FIFO_6   = out_q[2];
    assign out_FIFO_7   = out_q[3];
    assign cnt_0        = cnt_q[0];
    assign cnt_1        = cnt_q[1];
    assign cnt_2        = cnt_q[2];
    assign cnt_3        = cnt_q[3];
    assign stall        = stall_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_egress_router.sv
// Bench for egress_router: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_egress_router;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       v_in;
    logic [9:0] d_in;
    logic [3:0] af_in;

    logic       push_F4, push_F5, push_F6, push_F7;
    logic [9:0] out_FIFO_4, out_FIFO_5, out_FIFO_6, out_FIFO_7;
    logic       stall, overflow_err;
    logic [7:0] cnt_0, cnt_1, cnt_2, cnt_3;

    egress_router #(.DATA_W(10), .SKID_DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (rst),
        .valid_in       (v_in),
        .data_in        (d_in),
        .almost_full_P4 (af_in[0]),
        .almost_full_P5 (af_in[1]),
        .almost_full_P6 (af_in[2]),
        .almost_full_P7 (af_in[3]),
        .push_F4        (push_F4),
        .push_F5        (push_F5),
        .push_F6        (push_F6),
        .push_F7        (push_F7),
        .out_FIFO_4     (out_FIFO_4),
        .out_FIFO_5     (out_FIFO_5),
        .out_FIFO_6     (out_FIFO_6),
        .out_FIFO_7     (out_FIFO_7),
        .stall          (stall),
        .cnt_0          (cnt_0),
        .cnt_1          (cnt_1),
        .cnt_2          (cnt_2),
        .cnt_3          (cnt_3),
        .overflow_err   (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h expected=%0h (cycle %0d)", name, idx, act, exp, cyc);
        end
    endtask

    // Reference model: a plain queue stands in for the skid buffer.
    logic [9:0] q[$];
    logic       m_push [4];
    logic [9:0] m_out  [4];
    logic [7:0] m_cnt  [4];
    logic       m_stall, m_err;
    logic       m_has;
    logic [9:0] m_w;
    int         m_d;

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 4; i++) m_push[i] = 1'b0;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 4; i++) begin
                m_out[i] = '0;
                m_cnt[i] = '0;
            end
            m_stall = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_has = 1'b0;
            m_w   = '0;
            if (q.size() == 0) begin
                if (v_in && !af_in[d_in[9:8]]) begin
                    m_has = 1'b1;
                    m_w   = d_in;
                end else if (v_in) begin
                    q.push_back(d_in);
                end
            end else begin
                if (!af_in[q[0][9:8]]) begin
                    m_has = 1'b1;
                    m_w   = q.pop_front();
                end
                if (v_in) begin
                    if (q.size() == DEPTH) m_err = 1'b1;
                    else q.push_back(d_in);
                end
            end
            if (m_has) begin
                m_d = int'(m_w[9:8]);
                m_push[m_d] = 1'b1;
                m_out[m_d]  = m_w;
                m_cnt[m_d]  = m_cnt[m_d] + 8'd1;
            end
            m_stall = (q.size() != 0);
        end
    end

    logic       d_push [4];
    logic [9:0] d_out  [4];
    logic [7:0] d_cnt  [4];
    assign d_push[0] = push_F4;    assign d_push[1] = push_F5;
    assign d_push[2] = push_F6;    assign d_push[3] = push_F7;
    assign d_out[0]  = out_FIFO_4; assign d_out[1]  = out_FIFO_5;
    assign d_out[2]  = out_FIFO_6; assign d_out[3]  = out_FIFO_7;
    assign d_cnt[0]  = cnt_0;      assign d_cnt[1]  = cnt_1;
    assign d_cnt[2]  = cnt_2;      assign d_cnt[3]  = cnt_3;

    int         log_d[$];
    logic [9:0] log_w[$];
    int         log_c[$];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                check("push", i, 32'(d_push[i]), 32'(m_push[i]));
                check("out", i, 32'(d_out[i]), 32'(m_out[i]));
                check("cnt", i, 32'(d_cnt[i]), 32'(m_cnt[i]));
                if (d_push[i]) begin
                    log_d.push_back(i);
                    log_w.push_back(d_out[i]);
                    log_c.push_back(cyc);
                    $display("cycle %0d push F%0d data=%h", cyc, i + 4, d_out[i]);
                end
            end
            check("stall", 0, 32'(stall), 32'(m_stall));
            check("overflow", 0, 32'(overflow_err), 32'(m_err));
        end
    end

    task automatic drive(input logic v, input logic [9:0] d, input logic [3:0] af,
                         input logic r);
        v_in  = v;
        d_in  = d;
        af_in = af;
        rst   = r;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_d.delete();
        log_w.delete();
        log_c.delete();
    endtask

    initial begin
        drive(1'b0, '0, 4'h0, 1'b1);
        chk_en = 1'b1;
        drive(1'b1, 10'h3FF, 4'h0, 1'b1);
        check("lit_reset_stall", 0, 32'(stall), 32'd0);
        check("lit_reset_push7", 0, 32'(push_F7), 32'd0);
        check("lit_reset_out7", 0, 32'(out_FIFO_7), 32'd0);

        // Straight-through routing to all four ports
        clear_log();
        drive(1'b1, 10'h000, 4'h0, 1'b0);
        drive(1'b1, 10'h1AA, 4'h0, 1'b0);
        drive(1'b1, 10'h255, 4'h0, 1'b0);
        drive(1'b1, 10'h3FF, 4'h0, 1'b0);
        drive(1'b0, '0, 4'h0, 1'b0);
        drive(1'b0, '0, 4'h0, 1'b0);
        check("lit_t1_nlog", 0, 32'(log_d.size()), 32'd4);
        if (log_d.size() == 4) begin
            check("lit_t1_w0", 0, 32'(log_w[0]), 32'h000);
            check("lit_t1_d3", 0, 32'(log_d[3]), 32'd3);
            check("lit_t1_w3", 0, 32'(log_w[3]), 32'h3FF);
        end
        check("lit_t1_cnt1", 0, 32'(cnt_1), 32'd1);
        check("lit_t1_cnt3", 0, 32'(cnt_3), 32'd1);

        // Head-of-line blocking behind a full P5
        clear_log();
        drive(1'b1, 10'h101, 4'h2, 1'b0);
        drive(1'b1, 10'h002, 4'h2, 1'b0);
        drive(1'b0, '0, 4'h2, 1'b0);
        check("lit_t2_stall", 0, 32'(stall), 32'd1);
        check("lit_t2_nopush", 0, 32'(log_d.size()), 32'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 4'h0, 1'b0);
        check("lit_t2_nlog", 0, 32'(log_d.size()), 32'd2);
        if (log_d.size() == 2) begin
            check("lit_t2_first", 0, 32'(log_w[0]), 32'h101);
            check("lit_t2_second", 0, 32'(log_w[1]), 32'h002);
        end
        check("lit_t2_stall_end", 0, 32'(stall), 32'd0);

        // Overflow of the skid buffer
        clear_log();
        for (int i = 1; i <= 5; i++) drive(1'b1, 10'h3C0 + 10'(i), 4'h8, 1'b0);
        drive(1'b0, '0, 4'h8, 1'b0);
        check("lit_t3_err", 0, 32'(overflow_err), 32'd1);
        for (int i = 0; i < 7; i++) drive(1'b0, '0, 4'h0, 1'b0);
        check("lit_t3_nlog", 0, 32'(log_d.size()), 32'd4);
        if (log_d.size() == 4) begin
            for (int i = 0; i < 4; i++) check("lit_t3_order", i, 32'(log_w[i]), 32'h3C1 + i);
        end
        check("lit_t3_err_sticky", 0, 32'(overflow_err), 32'd1);

        // Simultaneous head issue and append at count 1
        clear_log();
        drive(1'b1, 10'h011, 4'h1, 1'b0);
        drive(1'b1, 10'h022, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 4'h0, 1'b0);
        check("lit_t4_nlog", 0, 32'(log_d.size()), 32'd2);
        if (log_d.size() == 2) begin
            check("lit_t4_first", 0, 32'(log_w[0]), 32'h011);
            check("lit_t4_second", 0, 32'(log_w[1]), 32'h022);
            check("lit_t4_gap", 0, 32'(log_c[1] - log_c[0]), 32'd1);
        end

        // Counter wrap on destination 2
        drive(1'b0, '0, 4'h0, 1'b1);
        for (int i = 0; i < 255; i++) drive(1'b1, {2'b10, 8'(i)}, 4'h0, 1'b0);
        drive(1'b0, '0, 4'h0, 1'b0);
        check("lit_t5_cnt255", 0, 32'(cnt_2), 32'hFF);
        drive(1'b1, 10'h2FF, 4'h0, 1'b0);
        drive(1'b0, '0, 4'h0, 1'b0);
        check("lit_t5_wrap", 0, 32'(cnt_2), 32'd0);

        // Reset with three buffered words
        drive(1'b1, 10'h0AA, 4'hF, 1'b0);
        drive(1'b1, 10'h155, 4'hF, 1'b0);
        drive(1'b1, 10'h2AA, 4'hF, 1'b0);
        check("lit_t6_stall_pre", 0, 32'(stall), 32'd1);
        drive(1'b1, 10'h3FF, 4'hF, 1'b1);
        clear_log();
        check("lit_t6_stall", 0, 32'(stall), 32'd0);
        check("lit_t6_cnt2", 0, 32'(cnt_2), 32'd0);
        check("lit_t6_out6", 0, 32'(out_FIFO_6), 32'd0);
        for (int i = 0; i < 6; i++) drive(1'b0, '0, 4'h0, 1'b0);
        check("lit_t6_nolog", 0, 32'(log_d.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
